// File: rtl/mem_lsu_if.sv
// Data-bus port bundle between the load/store unit (master) and data memory (slave).
// Handshake: the master raises bus_req with bus_we/addr/wdata/wstrb held stable; the access
// completes in the cycle the slave raises bus_ack (with bus_rdata valid), and bus_req drops next cycle.
interface mem_lsu_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: single-outstanding bus access with pipeline stall,
// alignment/type fault detection, load formatting and a no-ack watchdog.
module mem_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_dm_re,
   input  logic        mem_dm_we,
   input  logic [2:0]  mem_dm_type,
   input  logic [31:0] mem_alu_dout,
   input  logic [31:0] mem_dm_din,
   input  logic        mem_advance,
   output logic [31:0] mem_dm_dout,
   output logic        mem_stall,
   output logic        mem_fault,
   output logic        mem_bus_err,
   output logic [1:0]  dbg_state,
   mem_lsu_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   state_e      state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [3:0]  wstrb_q;
   logic [2:0]  type_q;
   logic        we_q;
   logic        err_q;
   logic [15:0] wd_q;

   logic        access;
   logic        type_ok;
   logic        align_ok;
   logic        fault;
   logic [31:0] store_data;
   logic [3:0]  store_strb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;

   // Access decode; a store takes priority when both re and we are high.
   always_comb begin
      access   = mem_dm_re | mem_dm_we;
      type_ok  = 1'b0;
      align_ok = 1'b1;
      case (mem_dm_type)
         3'b000, 3'b001, 3'b010: type_ok = 1'b1;
         3'b100, 3'b101:         type_ok = ~mem_dm_we;
         default:                type_ok = 1'b0;
      endcase
      case (mem_dm_type[1:0])
         2'b01:   align_ok = ~mem_alu_dout[0];
         2'b10:   align_ok = (mem_alu_dout[1:0] == 2'b00);
         default: align_ok = 1'b1;
      endcase
      fault = access & ~(type_ok & align_ok);
   end

   always_comb begin
      store_data = mem_dm_din;
      store_strb = 4'b1111;
      case (mem_dm_type[1:0])
         2'b00: begin
            store_data = {4{mem_dm_din[7:0]}};
            store_strb = 4'b0001 << mem_alu_dout[1:0];
         end
         2'b01: begin
            store_data = {2{mem_dm_din[15:0]}};
            store_strb = 4'b0011 << mem_alu_dout[1:0];
         end
         default: begin
            store_data = mem_dm_din;
            store_strb = 4'b1111;
         end
      endcase
   end

   always_comb begin
      ld_byte = rdata_q[7:0];
      case (addr_q[1:0])
         2'b00: ld_byte = rdata_q[7:0];
         2'b01: ld_byte = rdata_q[15:8];
         2'b10: ld_byte = rdata_q[23:16];
         2'b11: ld_byte = rdata_q[31:24];
         default: ld_byte = rdata_q[7:0];
      endcase
      ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (type_q)
         3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_fmt = {24'd0, ld_byte};
         3'b101:  ld_fmt = {16'd0, ld_half};
         default: ld_fmt = rdata_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wstrb_q <= '0;
         type_q  <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (access && !fault) begin
                  addr_q  <= mem_alu_dout;
                  type_q  <= mem_dm_type;
                  we_q    <= mem_dm_we;
                  wdata_q <= mem_dm_we ? store_data : 32'd0;
                  wstrb_q <= mem_dm_we ? store_strb : 4'b0000;
                  wd_q    <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               // An ack on the watchdog's last cycle still wins over the timeout.
               if (bus.bus_ack) begin
                  rdata_q <= bus.bus_rdata;
                  wd_q    <= '0;
                  state   <= DONE;
               end else if (wd_q == WD_LAST) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  wd_q    <= '0;
                  state   <= DONE;
               end else begin
                  wd_q <= wd_q + 16'd1;
               end
            end
            DONE: begin
               if (mem_advance) begin
                  err_q <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_stall   = ((state == IDLE) && access && !fault) || (state == BUSY);
   assign mem_fault   = (state == IDLE) && fault;
   assign mem_bus_err = (state == DONE) && err_q;
   assign mem_dm_dout = (state == DONE) ? ld_fmt : 32'd0;
   assign dbg_state   = state;

   assign bus.bus_req   = (state == BUSY);
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = {addr_q[31:2], 2'b00};
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, stores, faults, watchdog, DONE hold and reset mid-access.
module tb_mem_lsu;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DONE = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_dm_re, mem_dm_we, mem_advance;
   logic [2:0]  mem_dm_type;
   logic [31:0] mem_alu_dout, mem_dm_din, mem_dm_dout;
   logic        mem_stall, mem_fault, mem_bus_err;
   logic [1:0]  dbg_state;

   int tests_run = 0;
   int tests_failed = 0;

   int          o_stall, o_req, o_hold_req;
   logic        o_we, o_err, o_done, o_hold_err;
   logic [31:0] o_addr, o_wdata, o_dout, o_hold_dout;
   logic [3:0]  o_wstrb;
   logic [1:0]  o_hold_state;

   mem_lsu_if bus_if ();

   mem_lsu #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_dm_re    (mem_dm_re),
      .mem_dm_we    (mem_dm_we),
      .mem_dm_type  (mem_dm_type),
      .mem_alu_dout (mem_alu_dout),
      .mem_dm_din   (mem_dm_din),
      .mem_advance  (mem_advance),
      .mem_dm_dout  (mem_dm_dout),
      .mem_stall    (mem_stall),
      .mem_fault    (mem_fault),
      .mem_bus_err  (mem_bus_err),
      .dbg_state    (dbg_state),
      .bus          (bus_if.master)
   );

   always #5 clk = ~clk;

   // Drives one access, acks in BUSY cycle ack_k (0 = never), holds DONE for hold cycles.
   task automatic run_access(input logic re, input logic we, input logic [2:0] typ,
                             input logic [31:0] addr, input logic [31:0] din,
                             input int ack_k, input logic [31:0] rdata, input int hold);
      o_stall = 0; o_req = 0; o_hold_req = 0; o_done = 1'b0;
      o_we = 1'b0; o_err = 1'b0; o_addr = '0; o_wdata = '0; o_wstrb = '0; o_dout = '0;
      o_hold_dout = '0; o_hold_state = '0; o_hold_err = 1'b0;
      @(posedge clk); #1;
      mem_dm_re = re; mem_dm_we = we; mem_dm_type = typ;
      mem_alu_dout = addr; mem_dm_din = din; mem_advance = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         bus_if.bus_ack = 1'b0;
         if (mem_stall) o_stall++;
         if (bus_if.bus_req) begin
            o_req++;
            o_addr = bus_if.bus_addr; o_wdata = bus_if.bus_wdata;
            o_wstrb = bus_if.bus_wstrb; o_we = bus_if.bus_we;
            if (o_req == ack_k) begin
               bus_if.bus_ack = 1'b1;
               bus_if.bus_rdata = rdata;
            end
         end
         if (dbg_state == S_DONE) begin
            o_done = 1'b1; o_dout = mem_dm_dout; o_err = mem_bus_err;
            if (hold > 0) mem_advance = 1'b0;
            break;
         end
      end
      for (int h = 1; h <= hold; h++) begin
         @(negedge clk);
         if (bus_if.bus_req) o_hold_req++;
         o_hold_dout = mem_dm_dout; o_hold_state = dbg_state; o_hold_err = mem_bus_err;
         if (h == hold) mem_advance = 1'b1;
      end
      @(posedge clk); #1;
      mem_dm_re = 1'b0; mem_dm_we = 1'b0; bus_if.bus_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (dbg_state !== S_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
      tests_run++;
      if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb} !== 6'b0) begin tests_failed++; $display("FAIL reset_req_we_strb: got %b expected 000000", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb}); end
      tests_run++;
      if ({bus_if.bus_addr, bus_if.bus_wdata} !== 64'd0) begin tests_failed++; $display("FAIL reset_addr_wdata: got %h %h expected 0 0", bus_if.bus_addr, bus_if.bus_wdata); end
      tests_run++;
      if ({mem_dm_dout, mem_bus_err, mem_stall, mem_fault} !== 35'd0) begin tests_failed++; $display("FAIL reset_outputs: got dout=%h err=%b stall=%b fault=%b expected all 0", mem_dm_dout, mem_bus_err, mem_stall, mem_fault); end
   endtask

   task automatic test_lw();
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF, 0);
      tests_run++;
      if (o_done !== 1'b1) begin tests_failed++; $display("FAIL lw_done: got %b expected 1", o_done); end
      tests_run++;
      if (o_addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL lw_addr: got %h expected 00000100", o_addr); end
      tests_run++;
      if (o_stall !== 2) begin tests_failed++; $display("FAIL lw_stall_cycles: got %0d expected 2", o_stall); end
      tests_run++;
      if (o_req !== 1) begin tests_failed++; $display("FAIL lw_req_cycles: got %0d expected 1", o_req); end
      tests_run++;
      if ({o_we, o_wstrb} !== 5'b0) begin tests_failed++; $display("FAIL lw_we_strb: got %b expected 00000", {o_we, o_wstrb}); end
      tests_run++;
      if (o_dout !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL lw_dout: got %h expected deadbeef", o_dout); end
      @(negedge clk);
      tests_run++;
      if (mem_dm_dout !== 32'd0) begin tests_failed++; $display("FAIL lw_dout_idle: got %h expected 0", mem_dm_dout); end
   endtask

   task automatic test_load_format();
      logic [2:0]  t_type [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
      logic [31:0] t_addr [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
      logic [31:0] t_rd   [6] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h0000_7F00, 32'h0000_8001};
      logic [31:0] t_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_007F, 32'hFFFF_8001};
      for (int i = 0; i < 6; i++) begin
         run_access(1'b1, 1'b0, t_type[i], t_addr[i], 32'h0, 1, t_rd[i], 0);
         tests_run++;
         if (o_addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL ld_fmt_addr[%0d]: got %h expected 00000100", i, o_addr); end
         tests_run++;
         if (o_dout !== t_exp[i]) begin tests_failed++; $display("FAIL ld_fmt_dout[%0d]: got %h expected %h", i, o_dout, t_exp[i]); end
      end
   endtask

   task automatic test_store();
      run_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h0, 0);
      tests_run++;
      if ({o_addr, o_wdata} !== {32'h0000_0200, 32'hABCD_ABCD}) begin tests_failed++; $display("FAIL sh_addr_wdata: got %h %h expected 00000200 abcdabcd", o_addr, o_wdata); end
      tests_run++;
      if ({o_we, o_wstrb} !== 5'b1_1100) begin tests_failed++; $display("FAIL sh_we_strb: got %b expected 11100", {o_we, o_wstrb}); end
      tests_run++;
      if (o_req !== 3 || o_stall !== 4) begin tests_failed++; $display("FAIL sh_req_stall: got req=%0d stall=%0d expected req=3 stall=4", o_req, o_stall); end
      run_access(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_005A, 1, 32'h0, 0);
      tests_run++;
      if ({o_wdata, o_wstrb} !== {32'h5A5A_5A5A, 4'b0010}) begin tests_failed++; $display("FAIL sb_wdata_strb: got %h %b expected 5a5a5a5a 0010", o_wdata, o_wstrb); end
      // re and we both high: the store is performed.
      run_access(1'b1, 1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 2, 32'h0, 0);
      tests_run++;
      if ({o_addr, o_wdata, o_we, o_wstrb} !== {32'h0000_0204, 32'hCAFE_F00D, 1'b1, 4'b1111}) begin tests_failed++; $display("FAIL sw_fields: got %h %h %b %b expected 00000204 cafef00d 1 1111", o_addr, o_wdata, o_we, o_wstrb); end
   endtask

   task automatic test_fault();
      logic        f_re   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic        f_we   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [2:0]  f_type [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b001};
      logic [31:0] f_addr [6] = '{32'h101, 32'h103, 32'h206, 32'h100, 32'h100, 32'h201};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         mem_dm_re = f_re[i]; mem_dm_we = f_we[i]; mem_dm_type = f_type[i];
         mem_alu_dout = f_addr[i]; mem_dm_din = 32'hFFFF_FFFF; mem_advance = 1'b1;
         @(negedge clk);
         tests_run++;
         if ({mem_fault, mem_stall, bus_if.bus_req, mem_dm_dout} !== {3'b100, 32'd0}) begin tests_failed++; $display("FAIL fault[%0d]: got fault=%b stall=%b req=%b dout=%h expected 1 0 0 0", i, mem_fault, mem_stall, bus_if.bus_req, mem_dm_dout); end
         @(posedge clk); #1;
         mem_dm_re = 1'b0; mem_dm_we = 1'b0;
         @(negedge clk);
         tests_run++;
         if ({bus_if.bus_req, dbg_state, mem_fault} !== {1'b0, S_IDLE, 1'b0}) begin tests_failed++; $display("FAIL fault_after[%0d]: got req=%b state=%0d fault=%b expected 0 0 0", i, bus_if.bus_req, dbg_state, mem_fault); end
      end
   endtask

   task automatic test_timeout();
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 0, 32'h0, 0);
      tests_run++;
      if (o_req !== 4 || o_stall !== 5) begin tests_failed++; $display("FAIL timeout_req_stall: got req=%0d stall=%0d expected req=4 stall=5", o_req, o_stall); end
      tests_run++;
      if ({o_done, o_err, o_dout} !== {2'b11, 32'd0}) begin tests_failed++; $display("FAIL timeout_done: got done=%b err=%b dout=%h expected 1 1 0", o_done, o_err, o_dout); end
      @(negedge clk);
      tests_run++;
      if (mem_bus_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_err_clear: got %b expected 0", mem_bus_err); end
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0, 4, 32'h0BAD_F00D, 0);
      tests_run++;
      if ({o_err, o_dout} !== {1'b0, 32'h0BAD_F00D} || o_req !== 4) begin tests_failed++; $display("FAIL ack_at_timeout: got err=%b dout=%h req=%0d expected 0 0badf00d 4", o_err, o_dout, o_req); end
   endtask

   task automatic test_hold();
      run_access(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 2, 32'h1234_5678, 2);
      tests_run++;
      if (o_dout !== 32'h0000_1234) begin tests_failed++; $display("FAIL hold_dout_first: got %h expected 00001234", o_dout); end
      tests_run++;
      if ({o_hold_state, o_hold_dout, o_hold_err} !== {S_DONE, 32'h0000_1234, 1'b0}) begin tests_failed++; $display("FAIL hold_outputs: got state=%0d dout=%h err=%b expected 2 00001234 0", o_hold_state, o_hold_dout, o_hold_err); end
      tests_run++;
      if (o_hold_req !== 0) begin tests_failed++; $display("FAIL hold_no_reissue: got %0d req cycles expected 0", o_hold_req); end
      @(negedge clk);
      tests_run++;
      if ({dbg_state, bus_if.bus_req} !== {S_IDLE, 1'b0}) begin tests_failed++; $display("FAIL hold_release: got state=%0d req=%b expected 0 0", dbg_state, bus_if.bus_req); end
   endtask

   task automatic test_reset_busy();
      @(posedge clk); #1;
      mem_dm_re = 1'b1; mem_dm_we = 1'b0; mem_dm_type = 3'b010; mem_alu_dout = 32'h0000_0300;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (bus_if.bus_req !== 1'b1) begin tests_failed++; $display("FAIL rst_busy_req_before: got %b expected 1", bus_if.bus_req); end
      rst = 1'b1; mem_dm_re = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus_if.bus_req, dbg_state, bus_if.bus_addr} !== {1'b0, S_IDLE, 32'd0}) begin tests_failed++; $display("FAIL rst_busy_after: got req=%b state=%0d addr=%h expected 0 0 0", bus_if.bus_req, dbg_state, bus_if.bus_addr); end
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus_if.bus_req, dbg_state} !== {1'b0, S_IDLE}) begin tests_failed++; $display("FAIL rst_busy_stays_idle: got req=%b state=%0d expected 0 0", bus_if.bus_req, dbg_state); end
   endtask

   initial begin
      rst = 1'b1; mem_dm_re = 1'b0; mem_dm_we = 1'b0; mem_dm_type = 3'b000;
      mem_alu_dout = '0; mem_dm_din = '0; mem_advance = 1'b1;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
      test_reset();
      test_lw();
      test_load_format();
      test_store();
      test_fault();
      test_timeout();
      test_hold();
      test_reset_busy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
